// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects,
// multiplier FSM states, default bubble word and the single-cycle ALU.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_Z4  = 2'd1,
    FWD_Z5  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exec_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Single-cycle result; MUL and the unused codes 12-15 yield zero here.
  function automatic logic [31:0] alu_compute(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0000_0000;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'h0000_0000, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'h0000_0000, (a < b)};
      ALU_LUI:  r = b << 5'd16;
      default:  r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] z4_val,
                                          input logic [31:0] z5_val);
    logic [31:0] r;
    r = reg_val;
    case (sel)
      FWD_REG: r = reg_val;
      FWD_Z4:  r = z4_val;
      FWD_Z5:  r = z5_val;
      default: r = reg_val;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier keeping the low 32 product bits;
// one partial-product step per clock, 32 steps after start.
module mul_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic [31:0] acc_r;
  logic [4:0]  cnt_r;
  logic        busy_r;

  // Operand latch on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= 32'h0000_0000;
      mplier_r <= 32'h0000_0000;
      acc_r    <= 32'h0000_0000;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= 32'h0000_0000;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r  <= mcand_r << 5'd1;
      mplier_r <= mplier_r >> 5'd1;
      cnt_r    <= cnt_r + 5'd1;
      busy_r   <= (cnt_r != 5'd31);
    end else begin
      busy_r <= 1'b0;
    end
  end

  // done marks the cycle in which the final step is being taken.
  assign busy    = busy_r;
  assign done    = busy_r && (cnt_r == 5'd31);
  assign product = acc_r;

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage with operand bypass and the stage-4 register.
// Define EXEC_MUL_EN to enable the stalling iterative MUL path.
module execute_stage
  import exec_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IR3,
  input  logic [XLEN-1:0] PC3,
  input  logic [XLEN-1:0] A3,
  input  logic [XLEN-1:0] B3,
  input  logic [XLEN-1:0] S3,
  input  logic [3:0]      alu_op3,
  input  logic            valid3,
  input  logic            MemToReg3,
  input  logic            MemWrite3,
  input  logic            MemRead3,
  input  logic            RegWrite3,
  input  logic            JAL3,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [1:0]      fwd_s,
  input  logic [XLEN-1:0] Z5,
  output logic [XLEN-1:0] IR4,
  output logic [XLEN-1:0] PC4,
  output logic [XLEN-1:0] Z4,
  output logic [XLEN-1:0] S4,
  output logic            MemToReg4,
  output logic            MemWrite4,
  output logic            MemRead4,
  output logic            RegWrite4,
  output logic            JAL4,
  output logic            stall
);

  logic [XLEN-1:0] op_a_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] st_data_s;
  logic [XLEN-1:0] result_s;
  logic            ld_instr_s;

  assign op_a_s    = fwd_mux(fwd_a, A3, Z4, Z5);
  assign op_b_s    = fwd_mux(fwd_b, B3, Z4, Z5);
  assign st_data_s = fwd_mux(fwd_s, S3, Z4, Z5);

`ifdef EXEC_MUL_EN
  exec_state_e     state_r;
  exec_state_e     state_nxt_s;
  logic            stall_s;
  logic            mul_start_s;
  logic            mul_busy_s;
  logic            mul_done_s;
  logic [XLEN-1:0] mul_product_s;

  assign mul_start_s = (state_r == ST_IDLE) && valid3 && (alu_op3 == ALU_MUL);

  mul_iter u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (op_a_s),
    .b       (op_b_s),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // MUL sequencing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, stall and stage-4 load selection; a lost multiplier also ends BUSY.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    ld_instr_s  = 1'b0;
    result_s    = alu_compute(alu_op3, op_a_s, op_b_s);
    case (state_r)
      ST_IDLE: begin
        if (mul_start_s) begin
          stall_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          ld_instr_s  = valid3;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (mul_done_s || !mul_busy_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        ld_instr_s  = 1'b1;
        result_s    = mul_product_s;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Gating with rst_n drops stall in the same cycle reset asserts.
  assign stall = stall_s & rst_n;
`else
  assign ld_instr_s = valid3;
  assign result_s   = alu_compute(alu_op3, op_a_s, op_b_s);
  assign stall      = 1'b0;
`endif

  // Stage-4 pipeline register: instruction load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR4       <= NOP_WORD;
      PC4       <= 32'h0000_0000;
      Z4        <= 32'h0000_0000;
      S4        <= 32'h0000_0000;
      MemToReg4 <= 1'b0;
      MemWrite4 <= 1'b0;
      MemRead4  <= 1'b0;
      RegWrite4 <= 1'b0;
      JAL4      <= 1'b0;
    end else if (ld_instr_s) begin
      IR4       <= IR3;
      PC4       <= PC3;
      Z4        <= result_s;
      S4        <= st_data_s;
      MemToReg4 <= MemToReg3;
      MemWrite4 <= MemWrite3;
      MemRead4  <= MemRead3;
      RegWrite4 <= RegWrite3;
      JAL4      <= JAL3;
    end else begin
      IR4       <= NOP_WORD;
      PC4       <= 32'h0000_0000;
      Z4        <= 32'h0000_0000;
      S4        <= 32'h0000_0000;
      MemToReg4 <= 1'b0;
      MemWrite4 <= 1'b0;
      MemRead4  <= 1'b0;
      RegWrite4 <= 1'b0;
      JAL4      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases, randomized
// single-cycle traffic against a behavioural model, and MUL/reset runs.
module tb_execute_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] IR3 = 32'h0, PC3 = 32'h0, A3 = 32'h0, B3 = 32'h0, S3 = 32'h0, Z5 = 32'h0;
  logic [3:0]  alu_op3 = 4'd0;
  logic        valid3 = 1'b0;
  logic        MemToReg3 = 1'b0, MemWrite3 = 1'b0, MemRead3 = 1'b0, RegWrite3 = 1'b0, JAL3 = 1'b0;
  logic [1:0]  fwd_a = 2'd0, fwd_b = 2'd0, fwd_s = 2'd0;
  logic [31:0] IR4, PC4, Z4, S4;
  logic        MemToReg4, MemWrite4, MemRead4, RegWrite4, JAL4, stall;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [31:0] m_ir4, m_pc4, m_z4, m_s4;
  logic [4:0]  m_ctl;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .IR3(IR3), .PC3(PC3), .A3(A3), .B3(B3), .S3(S3),
    .alu_op3(alu_op3), .valid3(valid3), .MemToReg3(MemToReg3), .MemWrite3(MemWrite3),
    .MemRead3(MemRead3), .RegWrite3(RegWrite3), .JAL3(JAL3), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .fwd_s(fwd_s), .Z5(Z5), .IR4(IR4), .PC4(PC4), .Z4(Z4), .S4(S4),
    .MemToReg4(MemToReg4), .MemWrite4(MemWrite4), .MemRead4(MemRead4),
    .RegWrite4(RegWrite4), .JAL4(JAL4), .stall(stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU written directly from the op-code definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    int unsigned        sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] z4, input logic [31:0] z5);
    if (sel == 2'd1) return z4;
    else if (sel == 2'd2) return z5;
    else return r;
  endfunction

  task automatic model_bubble();
    m_ir4 = NOP; m_pc4 = 32'h0; m_z4 = 32'h0; m_s4 = 32'h0; m_ctl = 5'd0;
  endtask

  task automatic check_stage4(input string tag);
    check({tag, "_ir4"}, IR4, m_ir4);
    check({tag, "_pc4"}, PC4, m_pc4);
    check({tag, "_z4"},  Z4,  m_z4);
    check({tag, "_s4"},  S4,  m_s4);
    check({tag, "_ctl4"}, {27'h0, MemToReg4, MemWrite4, MemRead4, RegWrite4, JAL4}, {27'h0, m_ctl});
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] fs, input logic [31:0] z5, input logic [31:0] ir,
                       input logic [31:0] pc, input logic [4:0] ctl);
    valid3 = v; alu_op3 = op; A3 = a; B3 = b; S3 = s; fwd_a = fa; fwd_b = fb; fwd_s = fs;
    Z5 = z5; IR3 = ir; PC3 = pc;
    {MemToReg3, MemWrite3, MemRead3, RegWrite3, JAL3} = ctl;
  endtask

  // One single-cycle instruction (or bubble): drive at negedge, check one edge later.
  task automatic single(input string tag, input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] s, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [1:0] fs, input logic [31:0] z5,
                        input logic [31:0] ir, input logic [31:0] pc, input logic [4:0] ctl);
    logic [31:0] prev_z4;
    drive(v, op, a, b, s, fa, fb, fs, z5, ir, pc, ctl);
    #1 check({tag, "_stall"}, {31'h0, stall}, 32'h0);
    prev_z4 = m_z4;
    if (v) begin
      m_ir4 = ir; m_pc4 = pc; m_ctl = ctl;
      m_z4 = ref_alu(op, pick(fa, a, prev_z4, z5), pick(fb, b, prev_z4, z5));
      m_s4 = pick(fs, s, prev_z4, z5);
    end else begin
      model_bubble();
    end
    @(posedge clk);
    @(negedge clk);
    check_stage4(tag);
  endtask

`ifdef EXEC_MUL_EN
  // Presents a MUL and follows it edge by edge; reset_at >= 0 pulls rst_n in that cycle.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input int reset_at);
    logic [31:0] ir;
    logic [31:0] pc;
    ir = 32'h0220_8033;
    pc = 32'h0000_1004;
    drive(1'b1, 4'd11, a, b, s, 2'd0, 2'd0, 2'd0, 32'h0, ir, pc, 5'b00010);
    for (int c = 0; c < 34; c++) begin
      if (c == 1) begin
        fwd_a = 2'd2; fwd_b = 2'd2; Z5 = 32'hDEAD_BEEF;
      end
      #1 check($sformatf("%s_stall_c%0d", tag, c), {31'h0, stall}, (c < 33) ? 32'd1 : 32'd0);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        model_bubble();
        check({tag, "_rst_stall"}, {31'h0, stall}, 32'h0);
        check_stage4({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (c < 33) begin
        check($sformatf("%s_bubble_ir4_e%0d", tag, c + 1), IR4, NOP);
        check($sformatf("%s_bubble_z4_e%0d", tag, c + 1), Z4, 32'h0);
      end
    end
    m_ir4 = ir; m_pc4 = pc; m_z4 = a * b; m_s4 = s; m_ctl = 5'b00010;
    check_stage4({tag, "_result"});
  endtask
`endif

  initial begin
    model_bubble();
    drive(1'b1, 4'd0, 32'h1234_5678, 32'h1, 32'h9, 2'd0, 2'd0, 2'd0, 32'h0, 32'hABCD_0001, 32'h44, 5'b11111);
    #1 rst_n = 1'b0;
    #1 check_stage4("reset");
    check("reset_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1 check_stage4("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    single("add_wrap", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0033, 32'h104, 5'b00010);
    check("add_wrap_const", Z4, 32'h0);
    check("add_wrap_regwrite", {31'h0, RegWrite4}, 32'h1);
    single("sra", 1'b1, 4'd7, 32'h8000_0000, 32'h24, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h4000_5033, 32'h108, 5'b00010);
    check("sra_const", Z4, 32'hF800_0000);
    single("slt", 1'b1, 4'd8, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_2033, 32'h10C, 5'b00010);
    check("slt_const", Z4, 32'h1);
    single("sltu", 1'b1, 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_3033, 32'h110, 5'b00010);
    check("sltu_const", Z4, 32'h0);
    single("fwd_a_z5", 1'b1, 4'd0, 32'h9999_9999, 32'h3, 32'h0, 2'd2, 2'd0, 2'd0, 32'h7, 32'h0000_0033, 32'h114, 5'b00010);
    check("fwd_a_z5_const", Z4, 32'd10);
    single("make_55", 1'b1, 4'd0, 32'h50, 32'h5, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0033, 32'h118, 5'b00010);
    single("fwd_s_z4", 1'b1, 4'd0, 32'h1, 32'h1, 32'hCAFE_0000, 2'd0, 2'd0, 2'd1, 32'h0, 32'h0000_2023, 32'h11C, 5'b01000);
    check("fwd_s_z4_const", S4, 32'h55);
    single("lui", 1'b1, 4'd10, 32'h0, 32'h0000_ABCD, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0037, 32'h120, 5'b00010);
    single("undef_op", 1'b1, 4'd13, 32'h5, 32'h6, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0077, 32'h124, 5'b00011);
    single("bubble_mulop", 1'b0, 4'd11, 32'h5, 32'h6, 32'h7, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0000_0033, 32'h128, 5'b11111);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd11) op = op + 4'd1;
      single($sformatf("rand%0d", i), ($urandom_range(0, 3) != 0), op, $urandom, $urandom, $urandom,
             2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
             $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

`ifdef EXEC_MUL_EN
    run_mul("mul", 32'h0001_0001, 32'h0001_0001, 32'h0000_0777, -1);
    check("mul_const", Z4, 32'h0002_0001);
    single("after_mul", 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    run_mul("mul_rst", 32'h0001_0001, 32'h0001_0001, 32'h0, 10);
    model_bubble();
    run_mul("mul_rerun", 32'h0001_0001, 32'h0001_0001, 32'h0, -1);
    check("mul_rerun_const", Z4, 32'h0002_0001);
    single("after_rerun", 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      run_mul($sformatf("mul_rand%0d", i), $urandom, $urandom, $urandom, -1);
      single($sformatf("mul_gap%0d", i), 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    end
`else
    single("mul_off", 1'b1, 4'd11, 32'h0001_0001, 32'h0001_0001, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0220_8033, 32'h200, 5'b00010);
    check("mul_off_const", Z4, 32'h0);
`endif

    single("final_bubble", 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL provide parameter NOP_WORD, default 32'h0000_0000, the instruction word inserted into IR4 for bubbles.
REQ-003 SHALL provide port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL provide port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL provide port IR3, input, 32, the instruction word from decode.
REQ-006 SHALL provide port PC3, input, 32, the instruction PC+4, i.e. the JAL link value.
REQ-007 SHALL provide ports A3, B3 and S3, input, 32 each: operand A, operand B and store data from the register file.
REQ-008 SHALL provide port alu_op3, input, 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI, 11 MUL.
REQ-009 SHALL provide port valid3, input, 1, meaning the stage-3 inputs hold a real instruction.
REQ-010 SHALL provide ports MemToReg3, MemWrite3, MemRead3, RegWrite3 and JAL3, input, 1 each: control bits to pass through.
REQ-011 SHALL provide ports fwd_a, fwd_b and fwd_s, input, 2 each; operand select 0 takes the register value, 1 takes Z4 and 2 takes Z5.
REQ-012 SHALL provide port Z5, input, 32, the memory-access stage result used for bypass.
REQ-013 SHALL provide ports IR4, PC4, Z4 and S4, output reg, 32 each: the stage-4 pipeline register.
REQ-014 SHALL provide ports MemToReg4, MemWrite4, MemRead4, RegWrite4 and JAL4, output reg, 1 each.
REQ-015 SHALL provide port stall, output, 1; when high, upstream must hold all stage-3 inputs unchanged.

Function
REQ-016 SHALL compute all non-MUL ops with 1-cycle latency: the result is registered into Z4 on the next rising clk edge.
REQ-017 SHALL wrap ADD/SUB results modulo 2^32 and SHALL not detect overflow.
REQ-018 SHALL shift by B[4:0] only for SLL/SRL/SRA; SRA sign-fills.
REQ-019 SHALL output 1 or 0 for SLT (signed compare) and SLTU (unsigned compare).
REQ-020 SHALL compute LUI as B<<16.
REQ-021 SHALL output Z=0 for undefined op codes 12-15.
REQ-022 SHALL register S4 from the fwd_s-selected store data, so S4 = Z4 or Z5 when forwarding.
REQ-023 SHALL register PC4, IR4 and all control bits alongside Z4 on the same edge.
REQ-024 SHALL, when valid3=0 and the stage is not busy, load a bubble: IR4=NOP_WORD, Z4=0, S4=0, PC4=0 and all control bits 0.
REQ-025 SHALL run an FSM with states IDLE, BUSY and DONE.
REQ-026 SHALL, in IDLE with valid3=1 and alu_op3=MUL, drive stall=1 combinationally, latch the forwarded operands, clear the counter and go to BUSY; the stage-4 register takes a bubble on that edge.
REQ-027 SHALL, in BUSY, perform one shift-add iteration per cycle with stall=1 and load a bubble into stage 4 each cycle; when the counter reaches 31 the FSM goes to DONE.
REQ-028 SHALL, in DONE, drive stall=0 and load the low 32 bits of the product plus the held IR3/PC3/control into stage 4, then return to IDLE.
REQ-029 SHALL give MUL a latency of 34 edges from first presentation to Z4 valid.
REQ-030 SHALL ignore fwd_a and fwd_b while in BUSY or DONE, because the operands are latched at acceptance.
REQ-031 SHALL hold stall=0 in IDLE for every non-MUL input, including when valid3=0.

Reset
REQ-032 SHALL, while rst_n=0, force IR4=NOP_WORD, all other outputs 0, the state to IDLE and the counter to 0, immediately and without waiting for clk.
REQ-033 SHALL, on reset during BUSY, discard the partial product, and stall SHALL fall in the same cycle as reset asserts.

Configuration
REQ-034 SHALL use macro EXEC_MUL_EN: when defined, MUL behaves per REQ-025..030.
REQ-035 SHALL, when EXEC_MUL_EN is undefined, omit the FSM, counter and multiplier; alu_op3=11 then gives Z=0 in 1 cycle and stall is tied to 0.

Structure
REQ-036 SHALL define in shared package exec_pkg: the alu_op codes, the forward-select codes, the FSM state encoding and the NOP word constant.
REQ-037 SHALL place the multiplier in one sub-module, mul_iter, with interface start/a/b, busy/done and product[31:0].

Verification
REQ-038 SHALL cover: ADD with A3=0xFFFF_FFFF and B3=1 -> Z4=0 after 1 edge, with RegWrite4 copied.
REQ-039 SHALL cover: SRA with A3=0x8000_0000 and B3=0x24 -> Z4=0xF800_0000, since the shift is 4.
REQ-040 SHALL cover: SLT with A3=-1 and B3=1 -> 1, and SLTU with the same operands -> 0.
REQ-041 SHALL cover: fwd_a=2 with Z5=7, B3=3 and ADD -> Z4=10; fwd_s=1 with prior Z4=0x55 -> S4=0x55.
REQ-042 SHALL cover: MUL with 0x0001_0001 x 0x0001_0001 -> stall high for 33 cycles, bubbles in stage 4 meanwhile, and Z4=0x0002_0001 on edge 34.
REQ-043 SHALL cover: rst_n low at BUSY cycle 10 -> stall=0 and IR4=NOP_WORD immediately; after release the same MUL re-runs the full 34-edge latency.
